distance_avg_filter: RTL and testbench
======================================

Name: distance_avg_filter

Overview:
Moving-average (boxcar) filter between ADC_Data and the storage/binary_bcd path. It takes one 12-bit distance sample per strobe, keeps the last 2^LOG2_DEPTH samples in a ring buffer, and produces a rounded running mean. Its purpose is to steady the HEX readout and the AM/FM modulation depth against ADC jitter. The output feeds the storage register in place of the raw distance bus.

Parameters:
DATA_W, 12, width of distance samples and averaged output
LOG2_DEPTH, 4, log2 of window length (window = 16 samples); legal range 1..6

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_valid  input  1  single-cycle strobe; distance_in is valid this cycle
distance_in  input  DATA_W  raw distance sample from ADC_Data
clear  input  1  synchronous flush of window (e.g. from debounced key)
avg_out  output  DATA_W  rounded mean of last 2^LOG2_DEPTH samples
avg_valid  output  1  high while window is full and avg_out is meaningful
avg_strobe  output  1  single-cycle pulse each time avg_out updates
fill_count  output  LOG2_DEPTH+1  number of samples currently in window (0..2^LOG2_DEPTH)

Behaviour:
- Interface: one clock (clk); reset_n asynchronous, active-low. All state is cleared on reset assertion. Release is synchronous to clk.
- Reset values: avg_out=0, avg_valid=0, avg_strobe=0, fill_count=0, wr_ptr=0, accumulator=0. Buffer RAM contents are don't-care; they are never read before being written.
- Accumulator width is DATA_W+LOG2_DEPTH (16 bits by default). It cannot overflow.
- On sample_valid (and clear low), the block does the following at the same clock edge:
  - old = buf[wr_ptr] if fill_count == DEPTH, else 0.
  - acc_next = acc + distance_in - old.
  - buf[wr_ptr] = distance_in.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - fill_count increments and saturates at DEPTH.
- Read-before-write: old must be the value from the previous lap, never the incoming sample. The buffer is a synchronous-read RAM, so the read of buf[wr_ptr] is pre-fetched each cycle at the current wr_ptr. An implementation with registered combinational read and single-cycle update is also acceptable, provided latency below holds.
- Output: avg_out = (acc_next + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, which is round half up. The result is at most 2^DATA_W-1, so no saturation is needed.
- Latency: avg_out and avg_strobe are registered and update exactly 1 cycle after the sample_valid cycle.
- avg_strobe pulses on every accepted sample, including while the window is filling.
- avg_valid goes high in the same cycle that fill_count first reaches DEPTH. It stays high until clear or reset.
- While the window is not full, avg_out still updates per the formula (the missing samples count as zero). Consumers must gate on avg_valid.
- clear high: wr_ptr, fill_count, acc, avg_valid and avg_out are set to 0 on the next edge. avg_strobe is 0 that cycle.
- clear and sample_valid in the same cycle: clear wins and the sample is discarded.
- sample_valid held high for consecutive cycles: each cycle is a separate accepted sample. Back-to-back samples must be supported at full rate.
- Reset asserted mid-window: all state is lost immediately. After release the block behaves as from power-up.

Decomposition:
- Package dist_filter_pkg holds: DIST_W=12, DEFAULT_LOG2_DEPTH=4, a typedef dist_t (logic [DIST_W-1:0]), and a helper function for rounding-shift width.
- Sub-module dist_ring_buf is a simple dual-port RAM with 1 write and 1 synchronous read, DEPTH x DATA_W, no reset on the array, and inference-friendly for M9K.
- Control (pointer, fill counter, accumulator, output registers) stays in distance_avg_filter.

Test Plan:
- Reset then 16 strobes of distance_in=1000 -> avg_valid rises with the 16th strobe; avg_out=1000 one cycle after; fill_count=16.
- Full window at 1000, then 16 strobes of 2000 -> avg_out increases by 63 or 62 per step (e.g. step 1: (17000+8)>>4 = 1063). It reaches exactly 2000 after the 16th, which checks that ring wrap subtracts the correct oldest sample.
- Rounding: window filled with 15x0 and 1x8 -> avg_out=1 ((8+8)>>4); with 1x7 -> avg_out=0.
- Max value: 16 strobes of 4095, back-to-back every cycle -> avg_out=4095 with no overflow; avg_strobe high on 16 consecutive cycles, offset by 1.
- clear asserted together with sample_valid=1 while the window is full -> next cycle avg_out=0, avg_valid=0, fill_count=0, avg_strobe=0. The next 16 strobes of 500 give avg_out=500.
- reset_n pulsed low asynchronously (not clock-aligned) mid-fill at fill_count=7 -> outputs go to 0 immediately. After release, 16 strobes of 300 give avg_out=300 with no residue from earlier samples.

Source files
------------

// File: rtl/dist_filter_pkg.sv
// ---------------------------------------------------------------------------
// dist_filter_pkg
// Shared constants and helpers for the distance moving-average filter.
//   DIST_W             : width of a raw ADC distance sample
//   DEFAULT_LOG2_DEPTH : default log2 of the averaging window length
//   dist_t             : one distance sample
//   acc_width()        : accumulator width that holds a full window sum
//                        plus the rounding offset without overflow
// ---------------------------------------------------------------------------
package dist_filter_pkg;

  localparam int DIST_W             = 12;
  localparam int DEFAULT_LOG2_DEPTH = 4;

  typedef logic [DIST_W-1:0] dist_t;

  // A window of 2^log2_depth samples of (2^data_w - 1) plus half an LSB of
  // the shifted result still fits in data_w + log2_depth bits.
  function automatic int acc_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/distance_avg_filter_if.sv
// ---------------------------------------------------------------------------
// distance_avg_filter_if
// Sample/result bundle between the ADC data path and the averaging filter.
//   sample_valid : single-cycle strobe, distance_in valid this cycle
//   distance_in  : raw distance sample
//   clear        : synchronous window flush
//   avg_out      : rounded mean of the window
//   avg_valid    : window full, avg_out meaningful
//   avg_strobe   : one-cycle pulse per avg_out update
//   fill_count   : samples currently in the window
// Modports: master = sample source / result consumer, slave = filter.
// ---------------------------------------------------------------------------
interface distance_avg_filter_if
  import dist_filter_pkg::*;
#(
  parameter int DATA_W     = DIST_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
);

  logic                  sample_valid;
  logic [DATA_W-1:0]     distance_in;
  logic                  clear;
  logic [DATA_W-1:0]     avg_out;
  logic                  avg_valid;
  logic                  avg_strobe;
  logic [LOG2_DEPTH:0]   fill_count;

  modport master (
    output sample_valid, distance_in, clear,
    input  avg_out, avg_valid, avg_strobe, fill_count
  );

  modport slave (
    input  sample_valid, distance_in, clear,
    output avg_out, avg_valid, avg_strobe, fill_count
  );

endinterface

// File: rtl/dist_ring_buf.sv
// ---------------------------------------------------------------------------
// dist_ring_buf
// Simple dual-port RAM: one write port, one synchronous read port,
// 2^ADDR_W x DATA_W. The array has no reset so it maps onto block RAM.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, registered on clk
//   rd_data : data at rd_addr as of the previous edge
// ---------------------------------------------------------------------------
module dist_ring_buf
  import dist_filter_pkg::*;
#(
  parameter int DATA_W = DIST_W,
  parameter int ADDR_W = DEFAULT_LOG2_DEPTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/distance_avg_filter.sv
// ---------------------------------------------------------------------------
// distance_avg_filter
// Boxcar moving average over the last 2^LOG2_DEPTH distance samples with
// round-half-up output. Results are registered one cycle after each
// accepted sample.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : distance_avg_filter_if.slave (samples in, average out)
// ---------------------------------------------------------------------------
module distance_avg_filter
  import dist_filter_pkg::*;
#(
  parameter int DATA_W     = DIST_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  distance_avg_filter_if.slave bus
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] FULL = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (LOG2_DEPTH - 1);

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  strobe_q, strobe_d;

  logic                  accept;
  logic                  full;
  logic [DATA_W-1:0]     old_rd;
  logic [ACC_W-1:0]      old_ext;
  logic [ACC_W-1:0]      acc_sum;
  logic [ACC_W-1:0]      acc_rounded;
  logic [DATA_W-1:0]     avg_next;
  logic [LOG2_DEPTH-1:0] unused_frac;

  assign accept = bus.sample_valid & ~bus.clear;
  assign full   = (fill_q == FULL);

  // The read address is the next write pointer, so the RAM output always
  // holds the previous-lap sample at the current wr_ptr. Read and write
  // addresses never collide on a write cycle because the pointer advances.
  dist_ring_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.distance_in),
    .rd_addr (wr_ptr_d),
    .rd_data (old_rd)
  );

  // Until the window is full the slot being overwritten holds nothing yet.
  assign old_ext     = full ? {{LOG2_DEPTH{1'b0}}, old_rd} : '0;
  assign acc_sum     = acc_q + {{LOG2_DEPTH{1'b0}}, bus.distance_in} - old_ext;
  assign acc_rounded = acc_sum + ROUND_HALF;
  assign {avg_next, unused_frac} = acc_rounded;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    acc_d       = acc_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    strobe_d    = 1'b0;
    if (bus.clear) begin
      wr_ptr_d    = '0;
      fill_d      = '0;
      acc_d       = '0;
      avg_d       = '0;
      avg_valid_d = 1'b0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = full ? fill_q : fill_q + 1'b1;
      acc_d    = acc_sum;
      avg_d    = avg_next;
      strobe_d = 1'b1;
      if (fill_d == FULL) begin
        avg_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      acc_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bus.avg_out    = avg_q;
  assign bus.avg_valid  = avg_valid_q;
  assign bus.avg_strobe = strobe_q;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_distance_avg_filter.sv
module tb_distance_avg_filter;
  import dist_filter_pkg::*;

  localparam int L2    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  distance_avg_filter_if #(.DATA_W(DIST_W), .LOG2_DEPTH(L2)) bus ();

  distance_avg_filter #(.DATA_W(DIST_W), .LOG2_DEPTH(L2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int win[$];
  int exp_q[$];

  // Reference: plain list of the most recent samples, mean rounded half up.
  function automatic int model_push(input int v);
    int sum;
    win.push_back(v);
    if (win.size() > DEPTH) void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    return (sum + DEPTH / 2) / DEPTH;
  endfunction

  // Scoreboard consumer: every strobe must match the next expected average.
  always @(negedge clk) begin
    if (reset_n && bus.avg_strobe === 1'b1) begin
      int e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected avg_out=%0d expected no strobe", bus.avg_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.avg_out !== DIST_W'(e)) begin
          errors++;
          $display("FAIL scoreboard_avg got=%0d expected=%0d", bus.avg_out, e);
        end
      end
    end
  end

  task automatic send(input int v);
    bus.sample_valid = 1'b1;
    bus.distance_in  = DIST_W'(v);
    exp_q.push_back(model_push(v));
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    win.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count} !== {12'd0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state avg=%0d valid=%b strobe=%b fill=%0d expected all zero",
               bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH - 1; i++) send(1000);
    checks++;
    if (bus.fill_count !== 5'd15 || bus.avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_15 fill=%0d valid=%b expected fill=15 valid=0", bus.fill_count, bus.avg_valid);
    end
    send(1000);
    checks++;
    if (bus.fill_count !== 5'd16 || bus.avg_valid !== 1'b1 || bus.avg_out !== 12'd1000) begin
      errors++;
      $display("FAIL fill_16 fill=%0d valid=%b avg=%0d expected fill=16 valid=1 avg=1000",
               bus.fill_count, bus.avg_valid, bus.avg_out);
    end
  endtask

  task automatic test_wrap();
    send(2000);
    checks++;
    if (bus.avg_out !== 12'd1063) begin
      errors++;
      $display("FAIL wrap_first avg=%0d expected=1063", bus.avg_out);
    end
    for (int i = 0; i < DEPTH - 2; i++) send(2000);
    send(2000);
    checks++;
    if (bus.avg_out !== 12'd2000 || bus.fill_count !== 5'd16) begin
      errors++;
      $display("FAIL wrap_last avg=%0d fill=%0d expected avg=2000 fill=16", bus.avg_out, bus.fill_count);
    end
  endtask

  task automatic test_rounding();
    do_clear();
    for (int i = 0; i < DEPTH - 1; i++) send(0);
    send(8);
    checks++;
    if (bus.avg_out !== 12'd1 || bus.avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL round_up avg=%0d valid=%b expected avg=1 valid=1", bus.avg_out, bus.avg_valid);
    end
    do_clear();
    for (int i = 0; i < DEPTH - 1; i++) send(0);
    send(7);
    checks++;
    if (bus.avg_out !== 12'd0 || bus.avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL round_down avg=%0d valid=%b expected avg=0 valid=1", bus.avg_out, bus.avg_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    do_clear();
    sc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send(4095);
      if (bus.avg_strobe === 1'b1) sc++;
    end
    checks++;
    if (sc != DEPTH) begin
      errors++;
      $display("FAIL b2b_strobes count=%0d expected=%0d", sc, DEPTH);
    end
    checks++;
    if (bus.avg_out !== 12'd4095 || bus.avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_max avg=%0d valid=%b expected avg=4095 valid=1", bus.avg_out, bus.avg_valid);
    end
    idle(1);
    checks++;
    if (bus.avg_strobe !== 1'b0) begin
      errors++;
      $display("FAIL b2b_strobe_drop strobe=%b expected=0", bus.avg_strobe);
    end
  endtask

  task automatic test_clear_with_sample();
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.distance_in  = 12'd123;
    @(posedge clk);
    #1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    win.delete();
    checks++;
    if ({bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count} !== {12'd0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL clear_wins avg=%0d valid=%b strobe=%b fill=%0d expected all zero",
               bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count);
    end
    for (int i = 0; i < DEPTH; i++) send(500);
    checks++;
    if (bus.avg_out !== 12'd500 || bus.avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_clear avg=%0d valid=%b expected avg=500 valid=1", bus.avg_out, bus.avg_valid);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 7; i++) send(900);
    idle(1);
    checks++;
    if (bus.fill_count !== 5'd7) begin
      errors++;
      $display("FAIL pre_reset_fill fill=%0d expected=7", bus.fill_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count} !== {12'd0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL async_reset avg=%0d valid=%b strobe=%b fill=%0d expected all zero",
               bus.avg_out, bus.avg_valid, bus.avg_strobe, bus.fill_count);
    end
    exp_q.delete();
    win.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH - 1; i++) send(300);
    checks++;
    if (bus.avg_valid !== 1'b0 || bus.fill_count !== 5'd15) begin
      errors++;
      $display("FAIL post_reset_fill valid=%b fill=%0d expected valid=0 fill=15", bus.avg_valid, bus.fill_count);
    end
    send(300);
    checks++;
    if (bus.avg_out !== 12'd300 || bus.avg_valid !== 1'b1 || bus.fill_count !== 5'd16) begin
      errors++;
      $display("FAIL post_reset avg=%0d valid=%b fill=%0d expected avg=300 valid=1 fill=16",
               bus.avg_out, bus.avg_valid, bus.fill_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.distance_in  = '0;
    bus.clear        = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_rounding();
    test_back_to_back();
    test_clear_with_sample();
    test_async_reset();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
